// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: LM/SM sequencer issuing one memory transfer per set register-list bit.
// Define LMSM_BASE_WB_EN to write the final pointer back to base_reg after the last transfer.
module lmsm_sequencer #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              proc_rst,
   input  logic              start,
   input  logic              is_store,
   input  logic [7:0]        reg_mask,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [2:0]        base_reg,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [2:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              rf_wen,
   output logic [3:0]        xfer_cnt
);
`ifdef LMSM_BASE_WB_EN
   typedef enum logic [2:0] {IDLE, SCAN, REQ, WB, BASEWB, DONE} state_t;
   logic [2:0] base_q;
`else
   typedef enum logic [2:0] {IDLE, SCAN, REQ, WB, DONE} state_t;
   logic unused_base;
   assign unused_base = ^base_reg;
`endif
   state_t            state;
   logic [7:0]        rem_mask, mask_clr;
   logic [ADDR_W-1:0] ptr, ptr_inc;
   logic              dir, adv;
   logic [2:0]        cur, low;
   always_comb begin
      low = '0;
      for (int i = 7; i >= 0; i--)
         if (rem_mask[i]) low = 3'(i);
   end
   assign mask_clr  = rem_mask & ~(8'd1 << cur);
   assign ptr_inc   = ptr + ADDR_W'(1);
   assign mem_wdata = rf_rdata;
   // a transfer retires either on an SM ack or in the LM write-back cycle
   assign adv = (state == WB) || (state == REQ && mem_ack && dir);
   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         mem_rd   <= 1'b0;
         mem_wr   <= 1'b0;
         rf_wen   <= 1'b0;
         mem_addr <= '0;
         rf_wdata <= '0;
         rf_raddr <= '0;
         rf_waddr <= '0;
         xfer_cnt <= '0;
         rem_mask <= '0;
         ptr      <= '0;
         dir      <= 1'b0;
         cur      <= '0;
`ifdef LMSM_BASE_WB_EN
         base_q   <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               rem_mask <= reg_mask;
               ptr      <= base_addr;
               dir      <= is_store;
               xfer_cnt <= '0;
               busy     <= 1'b1;
`ifdef LMSM_BASE_WB_EN
               base_q   <= base_reg;
`endif
               done     <= reg_mask == 8'd0;
               state    <= reg_mask == 8'd0 ? DONE : SCAN;
            end
            SCAN: begin
               cur      <= low;
               rf_raddr <= low;
               mem_addr <= ptr;
               mem_rd   <= ~dir;
               mem_wr   <= dir;
               state    <= REQ;
            end
            REQ: if (mem_ack) begin
               mem_rd <= 1'b0;
               mem_wr <= 1'b0;
               if (!dir) begin
                  rf_wdata <= mem_rdata;
                  rf_waddr <= cur;
                  rf_wen   <= 1'b1;
                  state    <= WB;
               end
            end
            WB: rf_wen <= 1'b0;
`ifdef LMSM_BASE_WB_EN
            BASEWB: begin
               rf_wen <= 1'b0;
               done   <= 1'b1;
               state  <= DONE;
            end
`endif
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (adv) begin
            rem_mask <= mask_clr;
            ptr      <= ptr_inc;
            xfer_cnt <= xfer_cnt + 4'd1;
            if (mask_clr != 8'd0) state <= SCAN;
            else begin
`ifdef LMSM_BASE_WB_EN
               state    <= BASEWB;
               rf_wen   <= 1'b1;
               rf_waddr <= base_q;
               rf_wdata <= DATA_W'(ptr_inc);
`else
               state    <= DONE;
               done     <= 1'b1;
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: scoreboard bench for lmsm_sequencer with memory and register-file models.
// Honours LMSM_BASE_WB_EN when the design is built with it.
module tb_lmsm_sequencer;
`ifdef LMSM_BASE_WB_EN
   localparam int BWB = 1;
`else
   localparam int BWB = 0;
`endif
   localparam logic [1:0] EV_RD = 2'd0, EV_WR = 2'd1, EV_RF = 2'd2;
   typedef struct packed {logic [1:0] kind; logic [15:0] addr; logic [15:0] data;} ev_t;
   logic clk = 0, proc_rst = 0, start = 0, is_store = 0, mem_ack = 0;
   logic [7:0] reg_mask = 0;
   logic [15:0] base_addr = 0, mem_rdata = 0, mem_wdata, rf_rdata, mem_addr, rf_wdata;
   logic [2:0] base_reg = 3, rf_raddr, rf_waddr;
   logic busy, done, mem_rd, mem_wr, rf_wen;
   logic [3:0] xfer_cnt;
   logic [15:0] mem [0:65535];
   logic [15:0] rf [0:7];
   ev_t q[$];
   int vectors = 0, miscompares = 0, ack_dly = 0;
   lmsm_sequencer dut (
      .clk(clk), .proc_rst(proc_rst), .start(start), .is_store(is_store), .reg_mask(reg_mask),
      .base_addr(base_addr), .base_reg(base_reg), .busy(busy), .done(done), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .mem_wdata(mem_wdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .rf_wen(rf_wen), .xfer_cnt(xfer_cnt)
   );
   always #5 clk = ~clk;
   assign rf_rdata = rf[rf_raddr];
   // memory responder and scoreboard consumer
   initial begin
      int cnt;
      logic pend, p_rd, p_wr;
      logic [15:0] p_addr;
      ev_t e;
      cnt = 0; pend = 0; p_rd = 0; p_wr = 0; p_addr = 0;
      forever begin
         @(negedge clk);
         if (rf_wen) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL rf_unexpected: got write R%0d=%h, required none", rf_waddr, rf_wdata);
            end else begin
               e = q.pop_front();
               if (e.kind !== EV_RF || e.addr[2:0] !== rf_waddr || e.data !== rf_wdata) begin
                  miscompares++;
                  $display("FAIL rf_write: got R%0d=%h, required kind %0d R%0d=%h", rf_waddr, rf_wdata, e.kind, e.addr[2:0], e.data);
               end
            end
            rf[rf_waddr] = rf_wdata;
         end
         if (mem_rd || mem_wr) begin
            vectors++;
            if (mem_rd && mem_wr) begin
               miscompares++;
               $display("FAIL rd_wr_overlap: got rd=1 wr=1, required exclusive");
            end
            if (pend) begin
               vectors++;
               if (mem_addr !== p_addr || mem_rd !== p_rd || mem_wr !== p_wr) begin
                  miscompares++;
                  $display("FAIL stall_stable: got addr %h rd %b wr %b, required addr %h rd %b wr %b", mem_addr, mem_rd, mem_wr, p_addr, p_rd, p_wr);
               end
            end
            if (cnt == ack_dly) begin
               vectors++;
               if (q.size() == 0) begin
                  miscompares++;
                  $display("FAIL mem_unexpected: got access at %h, required none", mem_addr);
               end else begin
                  e = q.pop_front();
                  if (e.kind !== (mem_rd ? EV_RD : EV_WR) || e.addr !== mem_addr || (mem_wr && e.data !== mem_wdata)) begin
                     miscompares++;
                     $display("FAIL mem_access: got rd %b addr %h wdata %h, required kind %0d addr %h data %h", mem_rd, mem_addr, mem_wdata, e.kind, e.addr, e.data);
                  end
               end
               mem_ack = 1;
               mem_rdata = mem[mem_addr];
               if (mem_wr) mem[mem_addr] = mem_wdata;
               cnt = 0;
               pend = 0;
            end else begin
               mem_ack = 0;
               cnt++;
               pend = 1;
               p_addr = mem_addr; p_rd = mem_rd; p_wr = mem_wr;
            end
         end else begin
            mem_ack = 0;
            cnt = 0;
            pend = 0;
         end
      end
   end
   task automatic run_op(input logic st, input logic [7:0] m, input logic [15:0] b, input int inj);
      int n, lat, cyc;
      logic [15:0] p;
      p = b; n = 0;
      for (int i = 0; i < 8; i++)
         if (m[i]) begin
            if (!st) begin
               q.push_back({EV_RD, p, mem[p]});
               q.push_back({EV_RF, 16'(i), mem[p]});
            end else q.push_back({EV_WR, p, rf[i]});
            p++; n++;
         end
      if (n > 0 && BWB == 1) q.push_back({EV_RF, {13'd0, base_reg}, p});
      lat = (st ? 2 * n : 3 * n) + 1 + ((n > 0) ? BWB : 0);
      @(negedge clk);
      start = 1; is_store = st; reg_mask = m; base_addr = b;
      @(negedge clk);
      start = 0; cyc = 1;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start = (cyc == inj);
         if (start) begin is_store = 1; reg_mask = 8'h3C; base_addr = 16'h1234; end
      end
      start = 0;
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL done_timeout: got no done in %0d cycles, required done", cyc);
         return;
      end
      if (ack_dly == 0) begin
         vectors++;
         if (cyc !== lat) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc, lat);
         end
      end
      vectors++;
      if (xfer_cnt !== 4'(n) || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL xfer_cnt: got %0d busy %b, required %0d busy 1", xfer_cnt, busy, n);
      end
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_events: got %0d pending, required 0", q.size());
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || xfer_cnt !== 4'(n)) begin
         miscompares++;
         $display("FAIL after_done: got done %b busy %b cnt %0d, required 0 0 %0d", done, busy, xfer_cnt, n);
      end
   endtask
   task automatic test_reset();
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, done, mem_rd, mem_wr, rf_wen, mem_addr, rf_wdata, rf_raddr, rf_waddr, xfer_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got busy %b done %b rd %b wr %b wen %b addr %h wdata %h cnt %0d, required all 0", busy, done, mem_rd, mem_wr, rf_wen, mem_addr, rf_wdata, xfer_cnt);
      end
      proc_rst = 1;
   endtask
   task automatic test_lm_basic();
      mem[16'h0040] = 16'h1111; mem[16'h0041] = 16'h2222; ack_dly = 0; base_reg = 3;
      run_op(0, 8'h05, 16'h0040, 0);
      vectors++;
      if (rf[0] !== 16'h1111 || rf[2] !== 16'h2222) begin
         miscompares++;
         $display("FAIL lm_basic_rf: got R0=%h R2=%h, required 1111 2222", rf[0], rf[2]);
      end
   endtask
   task automatic test_sm_stall();
      rf[0] = 16'hAAAA; rf[7] = 16'h5555; ack_dly = 3; base_reg = 3;
      run_op(1, 8'h81, 16'h0100, 0);
      vectors++;
      if (mem[16'h0100] !== 16'hAAAA || mem[16'h0101] !== 16'h5555) begin
         miscompares++;
         $display("FAIL sm_stall_mem: got %h %h, required aaaa 5555", mem[16'h0100], mem[16'h0101]);
      end
      ack_dly = 0;
   endtask
   task automatic test_empty_mask();
      run_op(0, 8'h00, 16'h0500, 0);
   endtask
   task automatic test_lm_wrap_ignore_start();
      for (int i = 0; i < 8; i++) mem[16'hFFFE + 16'(i)] = 16'hC000 + 16'(i);
      base_reg = 5;
      run_op(0, 8'hFF, 16'hFFFE, 6);
      vectors++;
      if (rf[7] !== (BWB == 1 ? 16'hC007 : 16'hC007) || rf[2] !== 16'hC002) begin
         miscompares++;
         $display("FAIL wrap_rf: got R7=%h R2=%h, required c007 c002", rf[7], rf[2]);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL ignored_start: got busy %b, required 0", busy);
      end
      base_reg = 3;
   endtask
   task automatic test_reset_abort();
      int w;
      ack_dly = 20; w = 0;
      @(negedge clk);
      start = 1; is_store = 1; reg_mask = 8'h03; base_addr = 16'h0200;
      @(negedge clk);
      start = 0;
      while (!mem_wr && w < 20) begin @(negedge clk); w++; end
      repeat (2) @(negedge clk);
      vectors++;
      if (mem_wr !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_setup: got mem_wr %b, required 1", mem_wr);
      end
      #2 proc_rst = 0;
      #1;
      vectors++;
      if (mem_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || xfer_cnt !== 4'd0) begin
         miscompares++;
         $display("FAIL abort_reset: got wr %b busy %b done %b cnt %0d, required 0 0 0 0", mem_wr, busy, done, xfer_cnt);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_no_done: got done %b busy %b, required 0 0", done, busy);
      end
      proc_rst = 1;
      ack_dly = 0;
      mem[16'h0300] = 16'hBEEF;
      run_op(0, 8'h02, 16'h0300, 0);
      vectors++;
      if (rf[1] !== 16'hBEEF || mem[16'h0200] === rf[0]) begin
         miscompares++;
         $display("FAIL abort_recover: got R1=%h mem200=%h, required beef and no stray write", rf[1], mem[16'h0200]);
      end
   endtask
`ifdef LMSM_BASE_WB_EN
   task automatic test_base_wb();
      mem[16'h0010] = 16'h7777; mem[16'h0011] = 16'h8888; base_reg = 2; ack_dly = 0;
      run_op(0, 8'h06, 16'h0010, 0);
      vectors++;
      if (rf[1] !== 16'h7777 || rf[2] !== 16'h0012) begin
         miscompares++;
         $display("FAIL base_wb: got R1=%h R2=%h, required 7777 0012", rf[1], rf[2]);
      end
      base_reg = 3;
   endtask
`endif
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
      for (int i = 0; i < 8; i++) rf[i] = 16'h0F00 + 16'(i);
      mem[16'h0200] = 16'h0000;
      rf[0] = 16'h0F00;
      test_reset();
      test_lm_basic();
      test_sm_stall();
      test_empty_mask();
      test_lm_wrap_ignore_start();
      test_reset_abort();
`ifdef LMSM_BASE_WB_EN
      test_base_wb();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, required finish");
      $fatal(1, "watchdog");
   end
endmodule
